// File: rtl/ysyx_22041207_iter_mul_if.sv
// Multiply request/response bundle between the ALU (master) and the iterative multiplier (slave).
// Handshake: a request is taken on a clock edge where mul_valid & mul_ready & !flush; the result
// is presented for exactly one cycle with out_valid, with no back-pressure from the consumer.
interface ysyx_22041207_iter_mul_if #(
  parameter int XLEN = 64
);
  logic            mul_valid;
  logic            flush;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic [1:0]      mul_signed;
  logic            mulw;
  logic            mul_ready;
  logic            out_valid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output mul_valid, flush, multiplicand, multiplier, mul_signed, mulw,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, multiplicand, multiplier, mul_signed, mulw,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_22041207_iter_mul.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
// Operands are reduced to magnitudes on accept; the sign is reapplied to the full product at the end.
module ysyx_22041207_iter_mul #(
  parameter int XLEN = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22041207_iter_mul_if.slave     bus,
  output logic [1:0]                  dbg_state
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplr_q, mplr_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              mulw_q, mulw_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;

  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   acc_sh, mplr_sh;
  logic [2*XLEN-1:0] prod_raw, prod_w, prod;
  logic [CW-1:0]     last_cnt;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_op, b_op, a_mag, b_mag;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mulw_d   = mulw_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    // One iteration: conditional add into the high half, then shift {carry,acc,mplr} right.
    sum      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_sh   = sum[XLEN:1];
    mplr_sh  = {sum[0], mplr_q[XLEN-1:1]};
    prod_raw = {acc_sh, mplr_sh};
    // A 32-iteration run leaves the product 32 bits higher in the shift register.
    prod_w   = mulw_q ? (prod_raw >> 32) : prod_raw;
    prod     = neg_q ? (~prod_w + 1'b1) : prod_w;
    last_cnt = mulw_q ? CW'(31) : CW'(XLEN - 1);

    a_neg = !bus.mulw && bus.mul_signed[0] && bus.multiplicand[XLEN-1];
    b_neg = !bus.mulw && (bus.mul_signed == 2'b11) && bus.multiplier[XLEN-1];
    a_op  = bus.mulw ? {{(XLEN-32){1'b0}}, bus.multiplicand[31:0]} : bus.multiplicand;
    b_op  = bus.mulw ? {{(XLEN-32){1'b0}}, bus.multiplier[31:0]} : bus.multiplier;
    a_mag = a_neg ? (~a_op + 1'b1) : a_op;
    b_mag = b_neg ? (~b_op + 1'b1) : b_op;

    case (state_q)
      S_IDLE: begin
        if (bus.mul_valid && !bus.flush) begin
          mcand_d = a_mag;
          mplr_d  = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          mulw_d  = bus.mulw;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d  = acc_sh;
          mplr_d = mplr_sh;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == last_cnt) begin
            res_hi_d = mulw_q ? '0 : prod[2*XLEN-1:XLEN];
            res_lo_d = mulw_q ? {{(XLEN-32){prod[31]}}, prod[31:0]} : prod[XLEN-1:0];
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mulw_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mulw_q   <= mulw_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // A flush arriving in the DONE cycle must kill the pulse in that same cycle.
  assign bus.out_valid = (state_q == S_DONE) && !bus.flush;
  assign bus.mul_ready = (state_q == S_IDLE);
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_ysyx_22041207_iter_mul.sv
// Bench for the iterative multiplier: directed cases, randomized ops against a wide-arithmetic
// reference, flush/reset aborts and back-to-back/busy-ignore behaviour.
module tb_ysyx_22041207_iter_mul;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;

  ysyx_22041207_iter_mul_if #(.XLEN(64)) bus ();

  ysyx_22041207_iter_mul #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width product from sign/zero-extended operands.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sg, input logic w);
    logic [127:0] ae, be;
    logic [63:0]  p32;
    if (w) begin
      p32 = {32'b0, a[31:0]} * {32'b0, b[31:0]};
      return {64'b0, {{32{p32[31]}}, p32[31:0]}};
    end
    ae = sg[0] ? {{64{a[63]}}, a} : {64'b0, a};
    be = (sg == 2'b11) ? {{64{b[63]}}, b} : {64'b0, b};
    return ae * be;
  endfunction

  function automatic logic [63:0] pick_operand();
    logic [63:0] corner [5];
    corner[0] = 64'h0;
    corner[1] = 64'h1;
    corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corner[3] = 64'h8000_0000_0000_0000;
    corner[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    if ($urandom_range(0, 2) == 0) return corner[$urandom_range(0, 4)];
    return {$urandom, $urandom};
  endfunction

  // Issues one request at the next negedge (cycle 0) and waits for out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                        input logic w, output logic [63:0] hi, output logic [63:0] lo,
                        output int lat, output int busy_bad);
    @(negedge clk);
    bus.mul_valid    = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = sg;
    bus.mulw         = w;
    busy_bad = (bus.mul_ready !== 1'b1) ? 1 : 0;
    lat = -1;
    hi  = '0;
    lo  = '0;
    @(negedge clk);
    bus.mul_valid    = 1'b0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.mul_signed   = 2'($urandom_range(0, 3));
    bus.mulw         = 1'($urandom_range(0, 1));
    for (int n = 1; n <= 200; n++) begin
      if (bus.mul_ready !== 1'b0) busy_bad++;
      if (bus.out_valid === 1'b1) begin
        lat = n;
        hi  = bus.result_hi;
        lo  = bus.result_lo;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mul_valid = 1'b0;
    bus.flush = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    bus.mul_signed = 2'b00;
    bus.mulw = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    n_checks++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b out_valid=%b, required ready=1 out_valid=0",
               bus.mul_ready, bus.out_valid);
    end
    n_checks++;
    if (bus.result_hi !== 64'h0 || bus.result_lo !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_result: hi=%h lo=%h, required 0/0", bus.result_hi, bus.result_lo);
    end
  endtask

  task automatic test_directed();
    logic [63:0] a_t [5], b_t [5], hi_t [5], lo_t [5];
    logic [1:0]  sg_t [5];
    logic        w_t [5];
    logic [63:0] hi, lo;
    int lat, bad, exp_lat;
    a_t[0] = 64'd3;                  b_t[0] = 64'd5; sg_t[0] = 2'b00; w_t[0] = 1'b0;
    hi_t[0] = 64'h0;                 lo_t[0] = 64'd15;
    a_t[1] = 64'hFFFF_FFFF_FFFF_FFFE; b_t[1] = 64'd3; sg_t[1] = 2'b11; w_t[1] = 1'b0;
    hi_t[1] = 64'hFFFF_FFFF_FFFF_FFFF; lo_t[1] = 64'hFFFF_FFFF_FFFF_FFFA;
    a_t[2] = 64'hFFFF_FFFF_FFFF_FFFF; b_t[2] = 64'd2; sg_t[2] = 2'b00; w_t[2] = 1'b0;
    hi_t[2] = 64'h1;                 lo_t[2] = 64'hFFFF_FFFF_FFFF_FFFE;
    a_t[3] = 64'hFFFF_FFFF_FFFF_FFFF; b_t[3] = 64'd2; sg_t[3] = 2'b01; w_t[3] = 1'b0;
    hi_t[3] = 64'hFFFF_FFFF_FFFF_FFFF; lo_t[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    a_t[4] = 64'h1234_5678_7FFF_FFFF; b_t[4] = 64'd2; sg_t[4] = 2'b00; w_t[4] = 1'b1;
    hi_t[4] = 64'h0;                 lo_t[4] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      run_op(a_t[i], b_t[i], sg_t[i], w_t[i], hi, lo, lat, bad);
      exp_lat = w_t[i] ? 33 : 65;
      n_checks++;
      if (lat != exp_lat || bad != 0) begin
        n_fail++;
        $display("FAIL directed%0d_timing: latency=%0d ready_violations=%0d, required %0d/0",
                 i, lat, bad, exp_lat);
      end
      n_checks++;
      if (hi !== hi_t[i] || lo !== lo_t[i]) begin
        n_fail++;
        $display("FAIL directed%0d_value: hi=%h lo=%h, required hi=%h lo=%h",
                 i, hi, lo, hi_t[i], lo_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0]  a, b, hi, lo;
    logic [127:0] exp_p;
    logic [1:0]   sg;
    logic         w;
    int lat, bad;
    for (int i = 0; i < 40; i++) begin
      a  = pick_operand();
      b  = pick_operand();
      sg = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 3) == 0);
      exp_p = ref_prod(a, b, sg, w);
      run_op(a, b, sg, w, hi, lo, lat, bad);
      n_checks++;
      if (lat != (w ? 33 : 65) || bad != 0 || hi !== exp_p[127:64] || lo !== exp_p[63:0]) begin
        n_fail++;
        $display("FAIL random%0d: a=%h b=%h sg=%b w=%b got hi=%h lo=%h lat=%0d bad=%0d, required hi=%h lo=%h lat=%0d",
                 i, a, b, sg, w, hi, lo, lat, bad, exp_p[127:64], exp_p[63:0], w ? 33 : 65);
      end
    end
  endtask

  task automatic test_flush_busy();
    logic [63:0] hi, lo, old_hi, old_lo;
    int lat, bad, early;
    run_op(64'd3, 64'd5, 2'b00, 1'b0, hi, lo, lat, bad);
    old_hi = 64'h0;
    old_lo = 64'd15;
    early = 0;
    @(negedge clk);
    bus.mul_valid = 1'b1; bus.multiplicand = {$urandom, $urandom};
    bus.multiplier = {$urandom, $urandom}; bus.mul_signed = 2'b11; bus.mulw = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.mul_valid = 1'b0;
      if (bus.out_valid === 1'b1) early++;
      if (c == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++;
    if (bus.mul_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: ready=%b at cycle 11, required 1", bus.mul_ready);
    end
    n_checks++;
    if (bus.result_hi !== old_hi || bus.result_lo !== old_lo) begin
      n_fail++;
      $display("FAIL flush_hold: hi=%h lo=%h, required hi=%h lo=%h",
               bus.result_hi, bus.result_lo, old_hi, old_lo);
    end
    bus.mul_valid = 1'b1; bus.multiplicand = 64'd7; bus.multiplier = 64'd6;
    bus.mul_signed = 2'b00; bus.mulw = 1'b0;
    for (int c = 12; c <= 76; c++) begin
      @(negedge clk);
      bus.mul_valid = 1'b0;
      if (c < 76 && bus.out_valid === 1'b1) early++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result_lo !== 64'd42 || bus.result_hi !== 64'h0 || early != 0) begin
      n_fail++;
      $display("FAIL flush_restart: out_valid=%b hi=%h lo=%h early_pulses=%0d, required 1/0/42/0",
               bus.out_valid, bus.result_hi, bus.result_lo, early);
    end
  endtask

  task automatic test_flush_idle_done();
    int seen;
    @(negedge clk);
    bus.mul_valid = 1'b1; bus.flush = 1'b1;
    bus.multiplicand = 64'd9; bus.multiplier = 64'd9; bus.mul_signed = 2'b00; bus.mulw = 1'b0;
    @(negedge clk);
    bus.mul_valid = 1'b0; bus.flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (bus.out_valid === 1'b1 || bus.mul_ready !== 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_idle: %0d cycles busy or pulsing, required 0", seen);
    end
    bus.mul_valid = 1'b1; bus.multiplicand = 64'd11; bus.multiplier = 64'd13;
    seen = 0;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      bus.mul_valid = 1'b0;
      if (c == 65) begin
        bus.flush = 1'b1;
        #1;
      end
      if (bus.out_valid === 1'b1) seen++;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++;
    if (seen != 0 || bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: pulses=%0d ready=%b out_valid=%b, required 0/1/0",
               seen, bus.mul_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_midop();
    logic [63:0] hi, lo;
    int lat, bad, seen;
    run_op(64'd3, 64'd5, 2'b00, 1'b0, hi, lo, lat, bad);
    @(negedge clk);
    bus.mul_valid = 1'b1; bus.multiplicand = 64'd100; bus.multiplier = 64'd200;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.mul_valid = 1'b0;
      if (c == 20) rst = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.result_hi !== 64'h0 || bus.result_lo !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_midop: ready=%b out_valid=%b hi=%h lo=%h, required 1/0/0/0",
               bus.mul_ready, bus.out_valid, bus.result_hi, bus.result_lo);
    end
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_drop: %0d out_valid pulses after reset, required 0", seen);
    end
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, hi, lo, lat, bad);
    n_checks++;
    if (hi !== 64'h4000_0000_0000_0000 || lo !== 64'h0 || lat != 65 || bad != 0) begin
      n_fail++;
      $display("FAIL most_negative: hi=%h lo=%h lat=%0d bad=%0d, required 4000000000000000/0/65/0",
               hi, lo, lat, bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  a0, b0, a1, b1;
    logic [127:0] e0, e1;
    int first, second;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    e0 = ref_prod(a0, b0, 2'b11, 1'b0);
    e1 = ref_prod(a1, b1, 2'b11, 1'b0);
    first = -1; second = -1;
    @(negedge clk);
    bus.mul_valid = 1'b1; bus.multiplicand = a0; bus.multiplier = b0;
    bus.mul_signed = 2'b11; bus.mulw = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.multiplicand = a1;
        bus.multiplier = b1;
      end
      if (c == 67) bus.mul_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (first < 0) begin
          first = c;
          n_checks++;
          if (bus.result_hi !== e0[127:64] || bus.result_lo !== e0[63:0]) begin
            n_fail++;
            $display("FAIL busy_ignore_value: hi=%h lo=%h, required hi=%h lo=%h",
                     bus.result_hi, bus.result_lo, e0[127:64], e0[63:0]);
          end
        end else begin
          second = c;
          n_checks++;
          if (bus.result_hi !== e1[127:64] || bus.result_lo !== e1[63:0]) begin
            n_fail++;
            $display("FAIL back_to_back_value: hi=%h lo=%h, required hi=%h lo=%h",
                     bus.result_hi, bus.result_lo, e1[127:64], e1[63:0]);
          end
          break;
        end
      end
    end
    bus.mul_valid = 1'b0;
    n_checks++;
    if (first != 65 || second != 131) begin
      n_fail++;
      $display("FAIL back_to_back_timing: pulses at %0d and %0d, required 65 and 131", first, second);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_flush_busy();
    test_flush_idle_done();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
